// File: rtl/vga_scan_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_scan_sweeper: 640x480@60 raster timing plus frame-stepped ping-pong mu |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_scan_sweeper #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter logic [17:0] MU_MIN    = 18'h2_8000,
  parameter logic [17:0] MU_MAX    = 18'h3_F000,
  parameter logic [17:0] MU_STEP   = 18'h0_0100,
  parameter int          SWEEP_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sweep_en,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        frame_start,
  output logic [17:0] mu
);

  localparam logic [9:0] c_H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] c_V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0] c_DIV_LAST = 8'(SWEEP_DIV - 1);

  typedef enum logic [0:0] {
    S_UP   = 1'b0,
    S_DOWN = 1'b1
  } sweep_state_t;

  sweep_state_t r_state;
  logic [7:0]   r_div;

  logic         w_col_wrap;
  logic         w_row_wrap;
  logic         w_frame_wrap;
  logic [9:0]   w_col_nxt;
  logic [9:0]   w_row_nxt;
  logic [18:0]  w_mu_up;
  logic [17:0]  w_mu_dn;
  logic         w_up_hit;
  logic         w_dn_hit;

  assign w_col_wrap   = (col == c_H_LAST);
  assign w_row_wrap   = (row == c_V_LAST);
  assign w_frame_wrap = w_col_wrap && w_row_wrap;
  assign w_col_nxt    = w_col_wrap ? 10'd0 : col + 10'd1;
  assign w_row_nxt    = w_col_wrap ? (w_row_wrap ? 10'd0 : row + 10'd1) : row;

  // One extra bit keeps the upward sum from wrapping near the top of the code range.
  assign w_mu_up  = {1'b0, mu} + {1'b0, MU_STEP};
  assign w_up_hit = (w_mu_up >= {1'b0, MU_MAX});
  assign w_dn_hit = ({1'b0, mu} <= ({1'b0, MU_MIN} + {1'b0, MU_STEP}));
  assign w_mu_dn  = mu - MU_STEP;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      col         <= 10'd0;
      row         <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      visible     <= 1'b0;
      frame_start <= 1'b0;
      mu          <= MU_MIN;
      r_state     <= S_UP;
      r_div       <= 8'd0;
    end else begin
      col         <= w_col_nxt;
      row         <= w_row_nxt;
      // Decoding next-state counts keeps the flags aligned with the registered col/row.
      hsync       <= !((w_col_nxt >= c_HS_START) && (w_col_nxt < c_HS_END));
      vsync       <= !((w_row_nxt >= c_VS_START) && (w_row_nxt < c_VS_END));
      visible     <= (w_col_nxt < c_H_VIS) && (w_row_nxt < c_V_VIS);
      frame_start <= w_frame_wrap;

      if (w_frame_wrap && sweep_en) begin
        if (r_div != c_DIV_LAST) begin
          r_div <= r_div + 8'd1;
        end else begin
          r_div <= 8'd0;
          if (r_state == S_UP) begin
            if (w_up_hit) begin
              mu      <= MU_MAX;
              r_state <= S_DOWN;
            end else begin
              mu <= w_mu_up[17:0];
            end
          end else begin
            if (w_dn_hit) begin
              mu      <= MU_MIN;
              r_state <= S_UP;
            end else begin
              mu <= w_mu_dn;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_sweeper.sv
`default_nettype none
// Bench for vga_scan_sweeper: a full-size instance for line timing and three
// shrunken-raster instances for frame, sweep and reset behaviour.
module tb_vga_scan_sweeper;

  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 3;
  localparam int S_HT = SHV + SHF + SHS + SHB;
  localparam int S_FT = S_HT * (SVV + SVF + SVS + SVB);

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic sweep_en_d = 1'b1;

  always #5 CLK = ~CLK;

  logic [9:0]  a_col, a_row, b_col, b_row, c_col, c_row, d_col, d_row;
  logic        a_hs, a_vs, a_vis, a_fs, b_hs, b_vs, b_vis, b_fs;
  logic        c_hs, c_vs, c_vis, c_fs, d_hs, d_vs, d_vis, d_fs;
  logic [17:0] a_mu, b_mu, c_mu, d_mu;
  logic [41:0] a_vec, b_vec, c_vec, d_vec;

  assign a_vec = {a_col, a_row, a_hs, a_vs, a_vis, a_fs, a_mu};
  assign b_vec = {b_col, b_row, b_hs, b_vs, b_vis, b_fs, b_mu};
  assign c_vec = {c_col, c_row, c_hs, c_vs, c_vis, c_fs, c_mu};
  assign d_vec = {d_col, d_row, d_hs, d_vs, d_vis, d_fs, d_mu};

  vga_scan_sweeper u_a (
    .CLK(CLK), .RST(RST), .sweep_en(1'b1),
    .col(a_col), .row(a_row), .hsync(a_hs), .vsync(a_vs),
    .visible(a_vis), .frame_start(a_fs), .mu(a_mu)
  );

  vga_scan_sweeper #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .MU_MIN(18'd100), .MU_MAX(18'd130), .MU_STEP(18'd10), .SWEEP_DIV(1)
  ) u_b (
    .CLK(CLK), .RST(RST), .sweep_en(1'b1),
    .col(b_col), .row(b_row), .hsync(b_hs), .vsync(b_vs),
    .visible(b_vis), .frame_start(b_fs), .mu(b_mu)
  );

  vga_scan_sweeper #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .MU_MIN(18'd100), .MU_MAX(18'd125), .MU_STEP(18'd10), .SWEEP_DIV(1)
  ) u_c (
    .CLK(CLK), .RST(RST), .sweep_en(1'b1),
    .col(c_col), .row(c_row), .hsync(c_hs), .vsync(c_vs),
    .visible(c_vis), .frame_start(c_fs), .mu(c_mu)
  );

  vga_scan_sweeper #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .MU_MIN(18'd100), .MU_MAX(18'd130), .MU_STEP(18'd10), .SWEEP_DIV(3)
  ) u_d (
    .CLK(CLK), .RST(RST), .sweep_en(sweep_en_d),
    .col(d_col), .row(d_row), .hsync(d_hs), .vsync(d_vs),
    .visible(d_vis), .frame_start(d_fs), .mu(d_mu)
  );

  // Ping-pong sequences written out directly from the sweep rules.
  logic [17:0] tbl_b [6] = '{18'd100, 18'd110, 18'd120, 18'd130, 18'd120, 18'd110};
  logic [17:0] tbl_c [6] = '{18'd100, 18'd110, 18'd120, 18'd125, 18'd115, 18'd105};

  int checks = 0;
  int errors = 0;

  // Reference state: clocks since reset release and frames counted with sweep_en high.
  int n = 0;
  int en_frames_d = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n           <= 0;
      en_frames_d <= 0;
    end else begin
      n <= n + 1;
      if (((n + 1) % S_FT == 0) && sweep_en_d) en_frames_d <= en_frames_d + 1;
    end
  end

  function automatic logic [41:0] exp_vec(input int k, input int hv, input int hf,
                                          input int hs, input int hb, input int vv,
                                          input int vf, input int vs, input int vb,
                                          input logic [17:0] m);
    int ht, vt, cc, rr;
    logic h, v, vis, fs;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    cc  = k % ht;
    rr  = (k / ht) % vt;
    h   = !(cc >= hv + hf && cc < hv + hf + hs);
    v   = !(rr >= vv + vf && rr < vv + vf + vs);
    vis = (k > 0) && (cc < hv) && (rr < vv);
    fs  = (k > 0) && (k % (ht * vt) == 0);
    return {10'(cc), 10'(rr), h, v, vis, fs, m};
  endfunction

  function automatic logic [41:0] exp_full(input int k);
    return exp_vec(k, 640, 16, 96, 48, 480, 10, 2, 33, 18'h2_8000);
  endfunction

  function automatic logic [41:0] exp_small(input int k, input logic [17:0] m);
    return exp_vec(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, m);
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (a_vec !== exp_full(0)) begin errors++; $display("FAIL reset_a actual=%h expected=%h", a_vec, exp_full(0)); end
    checks++; if (b_vec !== exp_small(0, 18'd100)) begin errors++; $display("FAIL reset_b actual=%h expected=%h", b_vec, exp_small(0, 18'd100)); end
    checks++; if (c_vec !== exp_small(0, 18'd100)) begin errors++; $display("FAIL reset_c actual=%h expected=%h", c_vec, exp_small(0, 18'd100)); end
    checks++; if (d_vec !== exp_small(0, 18'd100)) begin errors++; $display("FAIL reset_d actual=%h expected=%h", d_vec, exp_small(0, 18'd100)); end
  endtask

  task automatic test_line();
    int hs_low, vis_cnt;
    hs_low  = 0;
    vis_cnt = 0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (a_vec !== exp_full(n)) begin errors++; $display("FAIL line_release actual=%h expected=%h", a_vec, exp_full(n)); end
    for (int i = 0; i < 1700; i++) begin
      @(negedge CLK);
      checks++;
      if (a_vec !== exp_full(n)) begin
        errors++;
        $display("FAIL line_scan n=%0d actual=%h expected=%h", n, a_vec, exp_full(n));
      end
      if (n < 800) begin
        hs_low  += int'(!a_hs);
        vis_cnt += int'(a_vis);
      end
    end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL line_hsync_width actual=%0d expected=96", hs_low); end
    checks++; if (vis_cnt != 639) begin errors++; $display("FAIL line_visible_count actual=%0d expected=639", vis_cnt); end
  endtask

  task automatic test_frames();
    int fs_cnt, f0;
    fs_cnt = 0;
    f0     = n / S_FT;
    for (int i = 0; i < 10 * S_FT; i++) begin
      @(negedge CLK);
      checks++;
      if (b_vec !== exp_small(n, tbl_b[(n / S_FT) % 6])) begin
        errors++;
        $display("FAIL frames_b n=%0d actual=%h expected=%h", n, b_vec, exp_small(n, tbl_b[(n / S_FT) % 6]));
      end
      checks++;
      if (c_vec !== exp_small(n, tbl_c[(n / S_FT) % 6])) begin
        errors++;
        $display("FAIL frames_c n=%0d actual=%h expected=%h", n, c_vec, exp_small(n, tbl_c[(n / S_FT) % 6]));
      end
      fs_cnt += int'(b_fs);
    end
    checks++;
    if (fs_cnt != n / S_FT - f0) begin
      errors++;
      $display("FAIL frames_pulse_count actual=%0d expected=%0d", fs_cnt, n / S_FT - f0);
    end
  endtask

  task automatic test_sweep_hold();
    int f0, f, p;
    logic [17:0] m;
    f0 = n / S_FT;
    for (int i = 0; i < 14 * S_FT; i++) begin
      @(negedge CLK);
      m = tbl_b[(en_frames_d / 3) % 6];
      checks++;
      if (d_vec !== exp_small(n, m)) begin
        errors++;
        $display("FAIL sweep_hold n=%0d actual=%h expected=%h", n, d_vec, exp_small(n, m));
      end
      f = n / S_FT - f0;
      p = n % S_FT;
      // Random mid-frame chatter must be ignored; the boundary value is fixed per frame.
      if (p >= 2 && p <= S_FT - 3) sweep_en_d = 1'($urandom);
      if (p == S_FT - 2) sweep_en_d = !(f == 4 || f == 5);
    end
    sweep_en_d = 1'b1;
  endtask

  task automatic test_reset_mid();
    int first_fs;
    int waited;
    waited = 0;
    while ((n % S_FT) != 4 * S_HT + 5 && waited < 2 * S_FT) begin
      @(negedge CLK);
      waited++;
    end
    checks++; if (waited >= 2 * S_FT) begin errors++; $display("FAIL rst_mid_position actual=%0d expected=%0d", n % S_FT, 4 * S_HT + 5); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (a_vec !== exp_full(0)) begin errors++; $display("FAIL rst_mid_async_a actual=%h expected=%h", a_vec, exp_full(0)); end
    checks++; if (b_vec !== exp_small(0, 18'd100)) begin errors++; $display("FAIL rst_mid_async_b actual=%h expected=%h", b_vec, exp_small(0, 18'd100)); end
    checks++; if (d_vec !== exp_small(0, 18'd100)) begin errors++; $display("FAIL rst_mid_async_d actual=%h expected=%h", d_vec, exp_small(0, 18'd100)); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (b_vec !== exp_small(0, 18'd100)) begin errors++; $display("FAIL rst_mid_release actual=%h expected=%h", b_vec, exp_small(0, 18'd100)); end
    first_fs = -1;
    for (int i = 1; i <= S_FT + S_HT; i++) begin
      @(negedge CLK);
      checks++;
      if (b_vec !== exp_small(n, tbl_b[(n / S_FT) % 6])) begin
        errors++;
        $display("FAIL rst_mid_scan n=%0d actual=%h expected=%h", n, b_vec, exp_small(n, tbl_b[(n / S_FT) % 6]));
      end
      if (b_fs && first_fs < 0) first_fs = i;
    end
    checks++; if (first_fs != S_FT) begin errors++; $display("FAIL rst_mid_first_frame actual=%0d expected=%0d", first_fs, S_FT); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_sweep_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
